dtc_therm_decoder: RTL and testbench

//  Receive-side decoder for the 7-bit thermometer class codes that the dtc_* decision-tree classifiers emit.

---
 rtl/dtc_therm_pkg.sv | 34 +++
 rtl/dtc_therm_decoder_hist.sv | 37 +++
 rtl/dtc_therm_decoder.sv | 85 ++++++++
 tb/tb_dtc_therm_decoder.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/dtc_therm_pkg.sv
// dtc_therm_pkg: shared widths, types and the thermometer decode function
// for the dtc_* thermometer class-code receivers.
package dtc_therm_pkg;

  localparam int TW = 7;
  localparam int LW = $clog2(TW + 1);

  typedef logic [TW-1:0] therm_t;
  typedef logic [LW-1:0] level_t;

  typedef struct packed {
    logic   err;
    level_t level;
  } therm_dec_t;

  // Level is the trailing-ones count; any one above the first zero is a bubble.
  function automatic therm_dec_t therm_decode(therm_t t);
    therm_dec_t r;
    logic       seen0;
    r     = '0;
    seen0 = 1'b0;
    for (int i = 0; i < TW; i++) begin
      if (!t[i]) begin
        seen0 = 1'b1;
      end else if (seen0) begin
        r.err = 1'b1;
      end else begin
        r.level = level_t'(i + 1);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/dtc_therm_decoder_hist.sv
// dtc_therm_hist: per-level saturating histogram with synchronous clear
// and combinational read; only built when DTC_THERM_HIST_EN is defined.
module dtc_therm_hist
  import dtc_therm_pkg::*;
#(
  parameter int HIST_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc_i,
  input  level_t            lvl_i,
  input  logic              clr_i,
  input  level_t            sel_i,
  output logic [HIST_W-1:0] cnt_o
);

  localparam int NB = 2 ** LW;
  localparam logic [HIST_W-1:0] MAXV = '1;

  logic [HIST_W-1:0] bin_q [NB];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NB; i++) bin_q[i] <= '0;
    end else if (clr_i) begin
      for (int i = 0; i < NB; i++) bin_q[i] <= '0;
    end else if (inc_i && bin_q[lvl_i] != MAXV) begin
      bin_q[lvl_i] <= bin_q[lvl_i] + 1'b1;
    end
  end

  always_comb begin
    cnt_o = '0;
    if (int'(sel_i) <= TW) cnt_o = bin_q[sel_i];
  end

endmodule

// File: rtl/dtc_therm_decoder.sv
// dtc_therm_decoder: registered valid/ready thermometer code decoder with
// malformed-code counter; DTC_THERM_HIST_EN adds a per-level histogram.
module dtc_therm_decoder
  import dtc_therm_pkg::*;
#(
  parameter int ERR_W  = 8,
  parameter int HIST_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  therm_t           in_therm,
  output logic             out_valid,
  input  logic             out_ready,
  output level_t           out_level,
  output logic             out_err,
  output logic [ERR_W-1:0] err_cnt
`ifdef DTC_THERM_HIST_EN
  ,
  input  level_t           hist_sel,
  input  logic             hist_clr,
  output logic [HIST_W-1:0] hist_cnt
`endif
);

  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  logic             valid_q;
  level_t           level_q;
  logic             err_q;
  logic [ERR_W-1:0] ecnt_q;
  logic [ERR_W-1:0] ecnt_d;
  logic             acc;
  therm_dec_t       dec;

  assign in_ready = !valid_q || out_ready;
  assign acc      = in_valid && in_ready;
  assign dec      = therm_decode(in_therm);

  always_comb begin
    ecnt_d = ecnt_q;
    if (acc && dec.err && ecnt_q != ERR_MAX)
      ecnt_d = ecnt_q + 1'b1;
  end

  // Output register only loads on accept, so an idle X bus never lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      level_q <= '0;
      err_q   <= 1'b0;
      ecnt_q  <= '0;
    end else begin
      ecnt_q <= ecnt_d;
      if (acc) begin
        valid_q <= 1'b1;
        level_q <= dec.level;
        err_q   <= dec.err;
      end else if (out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = valid_q;
  assign out_level = level_q;
  assign out_err   = err_q;
  assign err_cnt   = ecnt_q;

`ifdef DTC_THERM_HIST_EN
  dtc_therm_hist #(
    .HIST_W (HIST_W)
  ) u_hist (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (acc),
    .lvl_i (dec.level),
    .clr_i (hist_clr),
    .sel_i (hist_sel),
    .cnt_o (hist_cnt)
  );
`endif

endmodule

// File: tb/tb_dtc_therm_decoder.sv
// tb_dtc_therm_decoder: scoreboard bench for dtc_therm_decoder;
// histogram checks build only with DTC_THERM_HIST_EN.
module tb_dtc_therm_decoder;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] in_therm;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_level;
  logic       out_err;
  logic [7:0] err_cnt;
`ifdef DTC_THERM_HIST_EN
  logic [2:0]  hist_sel;
  logic        hist_clr;
  logic [15:0] hist_cnt;
`endif

  int n_chk;
  int n_err;
  int exp_errs;
  logic [3:0] sb [$];

  dtc_therm_decoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_therm  (in_therm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_level (out_level),
    .out_err   (out_err),
    .err_cnt   (err_cnt)
`ifdef DTC_THERM_HIST_EN
    ,
    .hist_sel  (hist_sel),
    .hist_clr  (hist_clr),
    .hist_cnt  (hist_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h @%0t", tag, act, exp, $time);
    end
  endtask

  // Expected {err, level}: level by scanning ones, err if code isn't a clean mask.
  function automatic logic [3:0] model(input logic [6:0] t);
    int n;
    logic [6:0] m;
    n = 0;
    while (n < 7 && t[n]) n++;
    m = '0;
    for (int i = 0; i < n; i++) m[i] = 1'b1;
    return {t != m, 3'(n)};
  endfunction

  always @(negedge clk) begin
    logic [3:0] e;
    if (rst_n) begin
      check("err_cnt", err_cnt, exp_errs);
      if (out_valid && out_ready) begin
        check("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("out_level", out_level, e[2:0]);
          check("out_err", out_err, e[3]);
        end
      end
      if (in_valid && in_ready) begin
        e = model(in_therm);
        sb.push_back(e);
        if (e[3] && exp_errs < 255) exp_errs++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [6:0] t);
    in_valid = 1'b1;
    in_therm = t;
    step();
  endtask

  initial begin
    logic [6:0] codes [4];
    codes[0] = 7'b0000000;
    codes[1] = 7'b0000001;
    codes[2] = 7'b0111111;
    codes[3] = 7'b1111111;
    n_chk = 0;
    n_err = 0;
    exp_errs = 0;
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_therm = 7'b0011111;
    out_ready = 1'b1;
`ifdef DTC_THERM_HIST_EN
    hist_sel = '0;
    hist_clr = 1'b0;
`endif
    step();
    step();
    check("rst_out_valid", out_valid, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_level", out_level, 0);
    rst_n = 1'b1;

    // 1: first transfer
    send(7'b0011111);
    check("t1_valid", out_valid, 1);
    check("t1_level", out_level, 5);
    check("t1_err", out_err, 0);

    // 2: back-to-back stream
    foreach (codes[i]) begin
      send(codes[i]);
      check("t2_nobubble", out_valid, 1);
    end
    in_valid = 1'b0;
    in_therm = 'x;
    step();
    check("t2_drain", out_valid, 0);

    // 3: back-pressure then accept-and-drain
    out_ready = 1'b0;
    send(7'b0000011);
    in_valid = 1'b0;
    in_therm = 'x;
    for (int i = 0; i < 5; i++) begin
      check("t3_in_ready", in_ready, 0);
      check("t3_hold_v", out_valid, 1);
      check("t3_hold_lvl", out_level, 2);
      step();
    end
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_therm = 7'b1111111;
    #1;
    check("t3_rdy_up", in_ready, 1);
    step();
    check("t3_new_lvl", out_level, 7);
    in_valid = 1'b0;
    step();

    // 4: malformed codes and counter saturation
    send(7'b0101111);
    check("t4_level", out_level, 4);
    check("t4_err", out_err, 1);
    check("t4_cnt", err_cnt, 1);
    for (int i = 0; i < 300; i++) send(7'b1011011);
    in_valid = 1'b0;
    step();
    check("t4_sat", err_cnt, 255);

`ifdef DTC_THERM_HIST_EN
    // 5: histogram bins and clear priority
    hist_clr = 1'b1;
    step();
    hist_clr = 1'b0;
    for (int i = 0; i < 3; i++) send(7'b0011111);
    send(7'b0000011);
    in_valid = 1'b0;
    step();
    hist_sel = 3'd5;
    #1;
    check("t5_bin5", hist_cnt, 3);
    hist_sel = 3'd2;
    #1;
    check("t5_bin2", hist_cnt, 1);
    hist_clr = 1'b1;
    send(7'b0011111);
    hist_clr = 1'b0;
    in_valid = 1'b0;
    hist_sel = 3'd5;
    #1;
    check("t5_clr5", hist_cnt, 0);
    hist_sel = 3'd2;
    #1;
    check("t5_clr2", hist_cnt, 0);
    step();
`endif

    // 6: async reset discards a stalled result
    out_ready = 1'b0;
    send(7'b0000111);
    in_valid = 1'b0;
    step();
    check("t6_pending", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_v", out_valid, 0);
    check("t6_in_ready", in_ready, 1);
    check("t6_err_cnt", err_cnt, 0);
    sb.delete();
    exp_errs = 0;
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t6_no_replay", out_valid, 0);
    end
    check("sb_empty_end", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
